// File: rtl/sx_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sx_bus_ctrl
//  Description : Am386SX local-bus cycle controller. It tracks the CLK2 phase
//                and samples ADS# at T-state boundaries. It classifies and
//                decodes each bus cycle into ROM/MEM/IO selects, inserts
//                per-region wait states and drives READY#. It also arbitrates
//                the bus between the CPU and one DMA master via HOLD/HLDA.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        CLK2 (twice the T-state rate)
//    reset_n    asynchronous active-low reset
//    ads_n      CPU ADS#
//    mio/dc/wr  CPU M/IO#, D/C#, W/R#
//    lock_n     CPU LOCK#
//    addr       CPU A[23:1]
//    ready_n    READY# to CPU
//    na_n       NA# to CPU, tied inactive (no pipelining)
//    rom_cs     ROM select
//    mem_cs     RAM select
//    io_cs      I/O select
//    cyc_wr     W/R# latched for the current cycle
//    inta_cyc   current cycle is an interrupt acknowledge
//    halt_cyc   current cycle is halt/shutdown
//    bus_err    one-clk pulse on a reserved cycle type
//    hold       HOLD to CPU
//    holda      HLDA from CPU (synchronous to clk)
//    dma_req    external master bus request
//    dma_gnt    external master owns the bus
//    state_dbg  current FSM state
// ============================================================================
module sx_bus_ctrl #(
   parameter int unsigned ROM_WS = 2,
   parameter int unsigned MEM_WS = 0,
   parameter int unsigned IO_WS  = 4,
   parameter int unsigned WS_W   = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ads_n,
   input  logic        mio,
   input  logic        dc,
   input  logic        wr,
   input  logic        lock_n,
   input  logic [23:1] addr,
   output logic        ready_n,
   output logic        na_n,
   output logic        rom_cs,
   output logic        mem_cs,
   output logic        io_cs,
   output logic        cyc_wr,
   output logic        inta_cyc,
   output logic        halt_cyc,
   output logic        bus_err,
   output logic        hold,
   input  logic        holda,
   input  logic        dma_req,
   output logic        dma_gnt,
   output logic [2:0]  state_dbg
);

   localparam logic [WS_W-1:0] c_ROM_WS = WS_W'(ROM_WS);
   localparam logic [WS_W-1:0] c_MEM_WS = WS_W'(MEM_WS);
   localparam logic [WS_W-1:0] c_IO_WS  = WS_W'(IO_WS);
   localparam logic [WS_W-1:0] c_ONE    = WS_W'(1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_WAIT = 3'd1,
      S_RDY  = 3'd2,
      S_HREQ = 3'd3,
      S_HACT = 3'd4
   } state_t;

   state_t          r_state,    w_state_nxt;
   logic            r_ph;
   logic [WS_W-1:0] r_wcnt,     w_wcnt_nxt;
   logic            r_ready_n,  w_ready_n_nxt;
   logic            r_rom_cs,   w_rom_cs_nxt;
   logic            r_mem_cs,   w_mem_cs_nxt;
   logic            r_io_cs,    w_io_cs_nxt;
   logic            r_cyc_wr,   w_cyc_wr_nxt;
   logic            r_inta,     w_inta_nxt;
   logic            r_halt,     w_halt_nxt;
   logic            r_err_pend, w_err_pend_nxt;
   logic            r_bus_err;
   logic            r_hold,     w_hold_nxt;
   logic            r_dma_gnt,  w_dma_gnt_nxt;

   // Cycle decode from the live pins; only used on the ADS-sample edge.
   logic            w_dec_rom, w_dec_mem, w_dec_io;
   logic            w_dec_inta, w_dec_halt, w_dec_rsv;
   logic [WS_W-1:0] w_dec_ws;
   logic            w_rom_hit;

   // Only A[23:16] take part in the region decode.
   logic            w_unused_addr;
   assign w_unused_addr = &{1'b0, addr[15:1]};

   assign w_rom_hit = (addr[23:16] == 8'hFF);

   always_comb begin
      w_dec_rom  = 1'b0;
      w_dec_mem  = 1'b0;
      w_dec_io   = 1'b0;
      w_dec_inta = 1'b0;
      w_dec_halt = 1'b0;
      w_dec_rsv  = 1'b0;
      w_dec_ws   = c_IO_WS;
      case ({mio, dc, wr})
         3'b000:         w_dec_inta = 1'b1;
         3'b001:         w_dec_rsv  = 1'b1;
         3'b010, 3'b011: w_dec_io   = 1'b1;
         3'b101:         w_dec_halt = 1'b1;
         default: begin  // 100 code read, 11x data
            if (w_rom_hit) begin
               w_dec_rom = 1'b1;
               w_dec_ws  = c_ROM_WS;
            end else begin
               w_dec_mem = 1'b1;
               w_dec_ws  = c_MEM_WS;
            end
         end
      endcase
   end

   // Next-state / next-output logic. r_ph high means the coming edge ends a
   // T-state; CPU-side decisions are only taken on those edges, while the
   // HOLD/HLDA handshake reacts on every edge.
   always_comb begin
      w_state_nxt    = r_state;
      w_wcnt_nxt     = r_wcnt;
      w_ready_n_nxt  = r_ready_n;
      w_rom_cs_nxt   = r_rom_cs;
      w_mem_cs_nxt   = r_mem_cs;
      w_io_cs_nxt    = r_io_cs;
      w_cyc_wr_nxt   = r_cyc_wr;
      w_inta_nxt     = r_inta;
      w_halt_nxt     = r_halt;
      w_err_pend_nxt = 1'b0;
      w_hold_nxt     = r_hold;
      w_dma_gnt_nxt  = r_dma_gnt;

      case (r_state)
         S_IDLE: begin
            if (r_ph) begin
               // A CPU cycle start wins over a DMA request on the same edge.
               if (!ads_n) begin
                  w_rom_cs_nxt   = w_dec_rom;
                  w_mem_cs_nxt   = w_dec_mem;
                  w_io_cs_nxt    = w_dec_io;
                  w_inta_nxt     = w_dec_inta;
                  w_halt_nxt     = w_dec_halt;
                  w_err_pend_nxt = w_dec_rsv;
                  w_cyc_wr_nxt   = wr;
                  w_wcnt_nxt     = w_dec_ws;
                  if (w_dec_ws == '0) begin
                     w_ready_n_nxt = 1'b0;
                     w_state_nxt   = S_RDY;
                  end else begin
                     w_state_nxt   = S_WAIT;
                  end
               end else if (dma_req && lock_n) begin
                  w_hold_nxt  = 1'b1;
                  w_state_nxt = S_HREQ;
               end
            end
         end

         S_WAIT: begin
            if (r_ph) begin
               w_wcnt_nxt = r_wcnt - c_ONE;
               if (r_wcnt == c_ONE) begin
                  w_ready_n_nxt = 1'b0;
                  w_state_nxt   = S_RDY;
               end
            end
         end

         S_RDY: begin
            if (r_ph) begin
               w_ready_n_nxt = 1'b1;
               w_rom_cs_nxt  = 1'b0;
               w_mem_cs_nxt  = 1'b0;
               w_io_cs_nxt   = 1'b0;
               w_inta_nxt    = 1'b0;
               w_halt_nxt    = 1'b0;
               if (dma_req && lock_n) begin
                  w_hold_nxt  = 1'b1;
                  w_state_nxt = S_HREQ;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end

         S_HREQ: begin
            if (holda) begin
               w_dma_gnt_nxt = 1'b1;
               w_state_nxt   = S_HACT;
            end else if (!dma_req) begin
               w_hold_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end

         S_HACT: begin
            // While granted, wait for the master to let go; once released,
            // stay here until the CPU drops HLDA and reclaims the bus.
            if (r_dma_gnt) begin
               if (!dma_req) begin
                  w_hold_nxt    = 1'b0;
                  w_dma_gnt_nxt = 1'b0;
               end
            end else if (!holda) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_ph       <= 1'b0;
         r_wcnt     <= '0;
         r_ready_n  <= 1'b1;
         r_rom_cs   <= 1'b0;
         r_mem_cs   <= 1'b0;
         r_io_cs    <= 1'b0;
         r_cyc_wr   <= 1'b0;
         r_inta     <= 1'b0;
         r_halt     <= 1'b0;
         r_err_pend <= 1'b0;
         r_bus_err  <= 1'b0;
         r_hold     <= 1'b0;
         r_dma_gnt  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ph       <= ~r_ph;
         r_wcnt     <= w_wcnt_nxt;
         r_ready_n  <= w_ready_n_nxt;
         r_rom_cs   <= w_rom_cs_nxt;
         r_mem_cs   <= w_mem_cs_nxt;
         r_io_cs    <= w_io_cs_nxt;
         r_cyc_wr   <= w_cyc_wr_nxt;
         r_inta     <= w_inta_nxt;
         r_halt     <= w_halt_nxt;
         r_err_pend <= w_err_pend_nxt;
         // Delayed one clk so the pulse lands on the edge after the sample.
         r_bus_err  <= r_err_pend;
         r_hold     <= w_hold_nxt;
         r_dma_gnt  <= w_dma_gnt_nxt;
      end
   end

   assign ready_n   = r_ready_n;
   assign na_n      = 1'b1;
   assign rom_cs    = r_rom_cs;
   assign mem_cs    = r_mem_cs;
   assign io_cs     = r_io_cs;
   assign cyc_wr    = r_cyc_wr;
   assign inta_cyc  = r_inta;
   assign halt_cyc  = r_halt;
   assign bus_err   = r_bus_err;
   assign hold      = r_hold;
   assign dma_gnt   = r_dma_gnt;
   assign state_dbg = r_state;

endmodule
`default_nettype wire
